matmul_arbiter: RTL

Round-robin arbiter and sequencer that shares one floating-point matrix multiplier engine among NUM_REQ requesters. It accepts one job at a time, drives the engine's load/ready/ack handshake, and returns the result to the requester that submitted the job. It sits between the requester ports and the single engine instance.

---
 rtl/matmul_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/matmul_arbiter.sv
// Round-robin arbiter and sequencer sharing one matrix-multiply engine among NUM_REQ requesters.
// Define MATMUL_ARB_TIMEOUT_EN to enable the WAIT watchdog that returns resp_err_o=1 on expiry.
module matmul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ROWS        = 2,
  parameter int unsigned INNER       = 2,
  parameter int unsigned COLS        = 2,
  parameter int unsigned MIN_LATENCY = 8,
  parameter int unsigned TIMEOUT     = 4096,
  localparam int unsigned A_W        = 32 * ROWS * INNER,
  localparam int unsigned B_W        = 32 * INNER * COLS,
  localparam int unsigned Z_W        = 32 * ROWS * COLS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*A_W-1:0] req_a_i,
  input  logic [NUM_REQ*B_W-1:0] req_b_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     resp_valid_o,
  input  logic [NUM_REQ-1:0]     resp_ready_i,
  output logic [Z_W-1:0]         resp_data_o,
  output logic                   resp_err_o,
  output logic [A_W-1:0]         mm_a_o,
  output logic [B_W-1:0]         mm_b_o,
  output logic                   mm_load_o,
  input  logic [Z_W-1:0]         mm_out_i,
  input  logic                   mm_out_ready_i,
  output logic                   mm_out_ack_o
);

  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntMax = (TIMEOUT > MIN_LATENCY) ? TIMEOUT : MIN_LATENCY;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StGrant = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StAck   = 3'd4;
  localparam logic [2:0] StResp  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [IdxW-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [A_W-1:0]     mm_a_q, mm_a_d;
  logic [B_W-1:0]     mm_b_q, mm_b_d;
  logic [Z_W-1:0]     resp_data_q, resp_data_d;
  logic               resp_err_q, resp_err_d;

  logic               pick_valid;
  logic [IdxW-1:0]    pick_idx;
  logic [IdxW-1:0]    cand;
  logic [A_W-1:0]     sel_a;
  logic [B_W-1:0]     sel_b;
  logic               out_hit;
  logic               timed_out;
  logic [NUM_REQ-1:0] grant_oh;

  // First requesting index strictly after last_q, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last_q) + k) % NUM_REQ);
      if (!pick_valid && req_valid_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IdxW'(i)) begin
        sel_a = req_a_i[i*A_W +: A_W];
        sel_b = req_b_i[i*B_W +: B_W];
      end
    end
  end

  // The engine may still hold ready from the previous job, so ready is only trusted late.
  assign out_hit = (cnt_q >= CntW'(MIN_LATENCY)) && mm_out_ready_i;

`ifdef MATMUL_ARB_TIMEOUT_EN
  assign timed_out = (cnt_q >= CntW'(TIMEOUT)) && !out_hit;
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mm_a_d      = mm_a_q;
    mm_b_d      = mm_b_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          mm_a_d  = sel_a;
          mm_b_d  = sel_b;
          state_d = StGrant;
        end
      end
      StGrant: state_d = StLoad;
      StLoad: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (out_hit) begin
          resp_data_d = mm_out_i;
          state_d     = StAck;
        end else if (timed_out) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = StAck;
        end
      end
      StAck: state_d = StResp;
      StResp: begin
        if (resp_ready_i[grant_q]) begin
          last_d     = grant_q;
          resp_err_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      last_q      <= IdxW'(NUM_REQ - 1);
      cnt_q       <= '0;
      mm_a_q      <= '0;
      mm_b_q      <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mm_a_q      <= mm_a_d;
      mm_b_q      <= mm_b_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign grant_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
  assign req_ready_o  = (state_q == StGrant) ? grant_oh : '0;
  assign resp_valid_o = (state_q == StResp) ? grant_oh : '0;
  assign mm_load_o    = (state_q == StLoad);
  assign mm_out_ack_o = (state_q == StAck);
  assign mm_a_o       = mm_a_q;
  assign mm_b_o       = mm_b_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;

endmodule
